online_div_q_select: RTL and testbench

//  Quotient-digit selection and residual register stage of the radix-2 online divider.

---
 rtl/online_div_q_select.sv | 152 +++++++++++++++
 tb/tb_online_div_q_select.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/online_div_q_select.sv
// Quotient-digit selection and residual register stage of the radix-2 online divider.
// Picks q_j in {-1,0,+1} from a short residual estimate and feeds w = 2v back to the adder.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, results of the previous run held
// S_DELAY | consuming the first DELTA x digits, no quotient digit yet
// S_ITER  | one quotient digit per enabled cycle, UNROLLING digits
// S_DONE  | one-cycle completion pulse, restart allowed
module online_div_q_select #(
  parameter int UNROLLING  = 64,
  parameter int ADDR_WIDTH = 7,
  parameter int EST_BITS   = 4,
  parameter int DELTA      = 3
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [UNROLLING-1:0]  v_plus_frac,
  input  logic [UNROLLING-1:0]  v_minus_frac,
  input  logic [1:0]            cout_one_in,
  input  logic [1:0]            cout_two_in,
  output logic [UNROLLING-1:0]  w_plus_frac,
  output logic [UNROLLING-1:0]  w_minus_frac,
  output logic [UNROLLING-1:0]  q_plus_vec,
  output logic [UNROLLING-1:0]  q_minus_vec,
  output logic [1:0]            cin_one,
  output logic [1:0]            cin_two,
  output logic [1:0]            q_digit,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Estimate thresholds: +1 at E >= 2^(EST_BITS-2), -1 at E <= -(2^(EST_BITS-2)+1)
  localparam int POS_TH_I = 2 ** (EST_BITS - 2);
  localparam logic signed [EST_BITS:0] POS_TH = (EST_BITS + 1)'(POS_TH_I);
  localparam logic signed [EST_BITS:0] NEG_TH = (EST_BITS + 1)'(-POS_TH_I - 1);

  localparam logic [ADDR_WIDTH-1:0] CNT_DELAY_LOAD = ADDR_WIDTH'(DELTA - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ITER_LOAD  = ADDR_WIDTH'(UNROLLING - 1);

  state_t                  state_r;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [EST_BITS-1:0]     est_plus;
  logic [EST_BITS-1:0]     est_minus;
  logic signed [EST_BITS:0] est;
  logic                    sel_pos;
  logic                    sel_neg;
  logic [UNROLLING-1:0]    digit_mask;
  logic [ADDR_WIDTH-1:0]   rd_addr_inc;
  logic                    cnt_tc;

  assign est_plus  = v_plus_frac[UNROLLING-1 -: EST_BITS];
  assign est_minus = v_minus_frac[UNROLLING-1 -: EST_BITS];
  assign est       = $signed({est_plus[EST_BITS-1], est_plus})
                   - $signed({est_minus[EST_BITS-1], est_minus});
  assign sel_pos   = (est >= POS_TH);
  assign sel_neg   = (est <= NEG_TH);

  // Down-counter holds the bit position of the digit being produced in ITER
  assign digit_mask  = {{(UNROLLING-1){1'b0}}, 1'b1} << cnt_r;
  assign rd_addr_inc = (rd_addr == {ADDR_WIDTH{1'b1}}) ? rd_addr : rd_addr + ADDR_WIDTH'(1);
  assign cnt_tc      = (cnt_r == '0);

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    if (enable) begin
      case (state_r)
        S_IDLE:  if (start) state_nxt = S_DELAY;
        S_DELAY: if (cnt_tc) state_nxt = S_ITER;
        S_ITER:  if (cnt_tc) state_nxt = S_DONE;
        S_DONE:  state_nxt = start ? S_DELAY : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_r == S_DELAY) || (state_r == S_ITER);
    done = (state_r == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      w_plus_frac  <= '0;
      w_minus_frac <= '0;
      q_plus_vec   <= '0;
      q_minus_vec  <= '0;
      cin_one      <= '0;
      cin_two      <= '0;
      q_digit      <= '0;
      rd_addr      <= '0;
      cnt_r        <= '0;
    end else if (enable) begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_plus_frac  <= '0;
            w_minus_frac <= '0;
            q_plus_vec   <= '0;
            q_minus_vec  <= '0;
            cin_one      <= '0;
            cin_two      <= '0;
            q_digit      <= '0;
            rd_addr      <= '0;
            cnt_r        <= CNT_DELAY_LOAD;
          end
        end
        S_DELAY: begin
          w_plus_frac  <= {v_plus_frac[UNROLLING-2:0], 1'b0};
          w_minus_frac <= {v_minus_frac[UNROLLING-2:0], 1'b0};
          cin_one      <= cout_one_in;
          cin_two      <= cout_two_in;
          q_digit      <= 2'b00;
          rd_addr      <= rd_addr_inc;
          cnt_r        <= cnt_tc ? CNT_ITER_LOAD : cnt_r - ADDR_WIDTH'(1);
        end
        S_ITER: begin
          w_plus_frac  <= {v_plus_frac[UNROLLING-2:0], 1'b0};
          w_minus_frac <= {v_minus_frac[UNROLLING-2:0], 1'b0};
          cin_one      <= cout_one_in;
          cin_two      <= cout_two_in;
          q_digit      <= {sel_pos, sel_neg};
          if (sel_pos) q_plus_vec  <= q_plus_vec | digit_mask;
          if (sel_neg) q_minus_vec <= q_minus_vec | digit_mask;
          rd_addr      <= rd_addr_inc;
          cnt_r        <= cnt_tc ? cnt_r : cnt_r - ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_online_div_q_select.sv
// Directed bench for online_div_q_select: digit selection, run timing, stall, reset and restart.
// Residual top nibbles cycle through a table whose digits are worked out by a reference selector.
module tb_online_div_q_select;

  logic        clk = 1'b0;
  logic        asyn_reset;
  logic        enable;
  logic        start;
  logic [63:0] v_plus_frac;
  logic [63:0] v_minus_frac;
  logic [1:0]  cout_one_in;
  logic [1:0]  cout_two_in;
  logic [63:0] w_plus_frac;
  logic [63:0] w_minus_frac;
  logic [63:0] q_plus_vec;
  logic [63:0] q_minus_vec;
  logic [1:0]  cin_one;
  logic [1:0]  cin_two;
  logic [1:0]  q_digit;
  logic [6:0]  rd_addr;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_qp;
  logic [63:0] exp_qm;

  // (p, m) nibbles: E = +6, -5, +3, 0, +4, -4, +15, -15
  logic [3:0] tbl_p [8] = '{4'h6, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0, 4'h7, 4'h8};
  logic [3:0] tbl_m [8] = '{4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h7};

  online_div_q_select dut (
    .clk          (clk),
    .asyn_reset   (asyn_reset),
    .enable       (enable),
    .start        (start),
    .v_plus_frac  (v_plus_frac),
    .v_minus_frac (v_minus_frac),
    .cout_one_in  (cout_one_in),
    .cout_two_in  (cout_two_in),
    .w_plus_frac  (w_plus_frac),
    .w_minus_frac (w_minus_frac),
    .q_plus_vec   (q_plus_vec),
    .q_minus_vec  (q_minus_vec),
    .cin_one      (cin_one),
    .cin_two      (cin_two),
    .q_digit      (q_digit),
    .rd_addr      (rd_addr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sel_ref(input logic [3:0] p, input logic [3:0] m);
    int ep, em, e;
    ep = int'(p);
    em = int'(m);
    if (p[3]) ep = ep - 16;
    if (m[3]) em = em - 16;
    e = ep - em;
    if (e >= 4) return 1;
    if (e <= -5) return -1;
    return 0;
  endfunction

  task automatic drive_v(input int j);
    logic [63:0] b;
    b = 64'h0123_4567_89AB_CDEF ^ (64'(j) * 64'h0000_0000_0001_1111);
    v_plus_frac  = {tbl_p[j % 8], b[59:0]};
    v_minus_frac = {tbl_m[j % 8], ~b[59:0]};
    cout_one_in  = 2'(j);
    cout_two_in  = ~2'(j);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wp"},   w_plus_frac, 64'h0);
    chk({tag, "_wm"},   w_minus_frac, 64'h0);
    chk({tag, "_qp"},   q_plus_vec, 64'h0);
    chk({tag, "_qm"},   q_minus_vec, 64'h0);
    chk({tag, "_cin"},  {cin_one, cin_two}, 64'h0);
    chk({tag, "_qd"},   q_digit, 64'h0);
    chk({tag, "_rd"},   rd_addr, 64'h0);
    chk({tag, "_busy"}, busy, 64'h0);
    chk({tag, "_done"}, done, 64'h0);
  endtask

  // One division from start; optional stall, ignored start pulse, or reset at a given digit
  task automatic run_op(input int stall_at, input int ign_start_at, input int rst_at);
    int d;
    logic [63:0] ewp, ewm, sqp, sqm, swp;
    logic [1:0]  sqd;
    logic [6:0]  srd;
    exp_qp = '0;
    exp_qm = '0;
    enable = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_rd",   rd_addr, 0);
    chk("start_qp",   q_plus_vec, 0);
    chk("start_qm",   q_minus_vec, 0);
    for (int k = 0; k < 3; k++) begin
      drive_v(100 + k);
      ewp = {v_plus_frac[62:0], 1'b0};
      tick();
      chk("delay_wp", w_plus_frac, ewp);
      chk("delay_qd", q_digit, 0);
      chk("delay_rd", rd_addr, 64'(k + 1));
      chk("delay_qp", q_plus_vec, 0);
      chk("delay_busy", busy, 1);
    end
    for (int j = 0; j < 64; j++) begin
      drive_v(j);
      d   = sel_ref(v_plus_frac[63:60], v_minus_frac[63:60]);
      ewp = {v_plus_frac[62:0], 1'b0};
      ewm = {v_minus_frac[62:0], 1'b0};
      if (j == ign_start_at) start = 1'b1;
      if (j == rst_at) asyn_reset = 1'b1;
      tick();
      start = 1'b0;
      if (j == rst_at) begin
        chk_all_zero("midrst");
        return;
      end
      if (d == 1)  exp_qp[63-j] = 1'b1;
      if (d == -1) exp_qm[63-j] = 1'b1;
      chk("iter_qd",  q_digit, (d == 1) ? 64'h2 : (d == -1) ? 64'h1 : 64'h0);
      chk("iter_qp",  q_plus_vec, exp_qp);
      chk("iter_qm",  q_minus_vec, exp_qm);
      chk("iter_wp",  w_plus_frac, ewp);
      chk("iter_wm",  w_minus_frac, ewm);
      chk("iter_cin", {cin_one, cin_two}, {60'h0, 2'(j), ~2'(j)});
      chk("iter_rd",  rd_addr, 64'(j + 4));
      chk("iter_busy", busy, (j == 63) ? 64'h0 : 64'h1);
      chk("iter_done", done, (j == 63) ? 64'h1 : 64'h0);
      if (j == stall_at) begin
        sqp = q_plus_vec; sqm = q_minus_vec; swp = w_plus_frac;
        sqd = q_digit;    srd = rd_addr;
        enable = 1'b0;
        for (int s = 0; s < 5; s++) begin
          drive_v(j + 37 + s);
          tick();
          chk("stall_qp", q_plus_vec, {1'b0, 63'(64'h2a) | 63'h0} & 64'h0 | sqp);
          chk("stall_qm", q_minus_vec, sqm);
          chk("stall_wp", w_plus_frac, swp);
          chk("stall_qd", q_digit, sqd);
          chk("stall_rd", rd_addr, srd);
          chk("stall_busy", busy, 1);
        end
        enable = 1'b1;
      end
    end
  endtask

  initial begin
    asyn_reset   = 1'b1;
    enable       = 1'b1;
    start        = 1'b1;
    v_plus_frac  = 64'hFFFF_FFFF_FFFF_FFFF;
    v_minus_frac = 64'h0;
    cout_one_in  = 2'b11;
    cout_two_in  = 2'b11;
    tick();
    tick();
    chk_all_zero("reset");
    asyn_reset = 1'b0;
    start      = 1'b0;

    // start while disabled is not taken
    enable = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("idle_dis_busy", busy, 0);
    chk("idle_dis_rd", rd_addr, 0);

    // plain run, then done held while disabled, then back to idle with results held
    run_op(-1, -1, -1);
    chk("run_bit63", q_plus_vec[63], 1);
    enable = 1'b0;
    tick();
    chk("done_hold", done, 1);
    enable = 1'b1;
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_qp", q_plus_vec, exp_qp);
    chk("idle_qm", q_minus_vec, exp_qm);
    chk("idle_rd", rd_addr, 67);

    // five-cycle stall in ITER
    run_op(10, -1, -1);
    tick();

    // reset at digit 20, then a clean run
    run_op(-1, -1, 20);
    asyn_reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    run_op(-1, -1, -1);

    // start during ITER is ignored; start in DONE restarts
    run_op(-1, 5, -1);
    chk("pre_restart_done", done, 1);
    chk("pre_restart_qp", q_plus_vec, exp_qp);
    run_op(-1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
